// File: rtl/vx_tensor_hgmma_sched_if.sv
// HGMMA scheduler bundle: warp requests, tensor-core initiate port,
// writeback monitor and per-warp status.
interface vx_tensor_hgmma_sched_if #(
  parameter int NUM_WARPS       = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int NW_WIDTH        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
);
  logic [NUM_WARPS-1:0]       req_valid;
  logic [NUM_WARPS-1:0]       req_wait;
  logic [NUM_WARPS*CNT_W-1:0] req_wait_n;
  logic [NUM_WARPS-1:0]       req_ready;
  logic                       init_valid;
  logic [NW_WIDTH-1:0]        init_wid;
  logic                       init_ready;
  logic                       wb_valid;
  logic                       wb_ready;
  logic [NW_WIDTH-1:0]        wb_wid;
  logic                       wb_last;
  logic [NUM_WARPS*CNT_W-1:0] outstanding;
  logic                       busy;
  logic                       err;

  modport master (
    output req_valid, req_wait, req_wait_n,
    output init_ready, wb_valid, wb_ready,
    output wb_wid, wb_last,
    input  req_ready, init_valid, init_wid,
    input  outstanding, busy, err
  );

  modport slave (
    input  req_valid, req_wait, req_wait_n,
    input  init_ready, wb_valid, wb_ready,
    input  wb_wid, wb_last,
    output req_ready, init_valid, init_wid,
    output outstanding, busy, err
  );
endinterface

// File: rtl/vx_tensor_hgmma_sched.sv
// Per-warp HGMMA scheduler: round-robin kick-off onto the tensor core,
// outstanding-count tracking and HGMMA_WAIT resolution for every warp.
module vx_tensor_hgmma_sched #(
  parameter int NUM_WARPS       = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int NW_WIDTH        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input logic                    clk,
  input logic                    reset,
  vx_tensor_hgmma_sched_if.slave bus
);
  logic [CNT_W-1:0]     cnt [NUM_WARPS];
  logic [NW_WIDTH-1:0]  rr_ptr;
  logic [NW_WIDTH-1:0]  gnt;
  logic [NW_WIDTH-1:0]  gnt_nxt;
  logic [NUM_WARPS-1:0] cand;
  logic [NUM_WARPS-1:0] inc;
  logic [NUM_WARPS-1:0] dec;
  logic                 found;
  logic                 fire_i;
  logic                 fire_wb;
  logic                 bad_wid;
  logic                 err_q;

  always_comb begin
    cand = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      cand[w] = bus.req_valid[w] && !bus.req_wait[w]
             && (int'(cnt[w]) < MAX_OUTSTANDING);
    end
  end

  // First candidate at or after rr_ptr, wrapping once.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      int idx;
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_WARPS) idx = idx - NUM_WARPS;
      if (!found && cand[idx]) begin
        found = 1'b1;
        gnt   = NW_WIDTH'(idx);
      end
    end
  end

  assign gnt_nxt = (int'(gnt) + 1 == NUM_WARPS) ? '0 : gnt + 1'b1;

  assign bus.init_valid = found && !reset;
  assign bus.init_wid   = gnt;
  assign fire_i         = bus.init_valid && bus.init_ready;
  assign fire_wb        = bus.wb_valid && bus.wb_ready && bus.wb_last;
  assign bad_wid        = int'(bus.wb_wid) >= NUM_WARPS;

  always_comb begin
    bus.req_ready = '0;
    inc           = '0;
    dec           = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      inc[w] = fire_i && (gnt == NW_WIDTH'(w));
      dec[w] = fire_wb && !bad_wid && (bus.wb_wid == NW_WIDTH'(w));
      if (bus.req_valid[w] && !reset) begin
        if (bus.req_wait[w])
          bus.req_ready[w] = cnt[w] <= bus.req_wait_n[w*CNT_W +: CNT_W];
        else
          bus.req_ready[w] = inc[w];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) cnt[w] <= '0;
      rr_ptr <= '0;
      err_q  <= 1'b0;
    end else begin
      if (fire_i) rr_ptr <= gnt_nxt;
      if (fire_wb && bad_wid) err_q <= 1'b1;
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (inc[w] && !dec[w]) begin
          cnt[w] <= cnt[w] + 1'b1;
        end else if (dec[w] && !inc[w]) begin
          if (cnt[w] == '0) err_q <= 1'b1;
          else cnt[w] <= cnt[w] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.outstanding = '0;
    bus.busy        = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      bus.outstanding[w*CNT_W +: CNT_W] = cnt[w];
      bus.busy = bus.busy | (cnt[w] != '0);
    end
  end

  assign bus.err = err_q;
endmodule
